// File: rtl/bin_to_bcd.sv
// Sequential 16-bit binary to 4-digit packed BCD converter (shift-and-add-3).
// Results above 9999 saturate to 9999 and raise overflow_o.
module bin_to_bcd (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] binary_in,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [15:0] bcd_o,
    output logic        valid_o,
    output logic        overflow_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_shift;
    logic [19:0] r_scratch;
    logic [4:0]  r_count;
    logic [15:0] r_bcd;
    logic        r_ovf;

    logic        w_accept;
    logic        w_iter;
    logic        w_last;
    logic [19:0] w_adj;
    logic [19:0] w_scratch_nxt;
    logic [15:0] w_shift_nxt;
    logic [15:0] w_res_bcd;
    logic        w_res_ovf;

    function automatic logic [3:0] add3_digit(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd5) begin
            r = d + 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

    function automatic logic [19:0] add3_all(input logic [19:0] s);
        logic [19:0] r;
        r = 20'd0;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = add3_digit(s[i*4 +: 4]);
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and iteration control
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_iter      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (valid_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                w_iter = 1'b1;
                if (r_count == 5'd15) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // One double-dabble step: correct digits, then shift operand MSB into scratch
    always_comb begin
        w_adj         = add3_all(r_scratch);
        w_scratch_nxt = {w_adj[18:0], r_shift[15]};
        w_shift_nxt   = {r_shift[14:0], 1'b0};
        if (w_scratch_nxt[19:16] == 4'd0) begin
            w_res_bcd = w_scratch_nxt[15:0];
            w_res_ovf = 1'b0;
        end else begin
            w_res_bcd = 16'h9999;
            w_res_ovf = 1'b1;
        end
    end

    // Datapath: operand capture, iterations, and result registration
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_shift   <= 16'd0;
            r_scratch <= 20'd0;
            r_count   <= 5'd0;
            r_bcd     <= 16'h0000;
            r_ovf     <= 1'b0;
        end else if (w_accept) begin
            r_shift   <= binary_in;
            r_scratch <= 20'd0;
            r_count   <= 5'd0;
        end else if (w_iter) begin
            r_shift   <= w_shift_nxt;
            r_scratch <= w_scratch_nxt;
            r_count   <= r_count + 5'd1;
            if (w_last) begin
                r_bcd <= w_res_bcd;
                r_ovf <= w_res_ovf;
            end else begin
                r_bcd <= r_bcd;
                r_ovf <= r_ovf;
            end
        end else begin
            r_shift   <= r_shift;
            r_scratch <= r_scratch;
            r_count   <= r_count;
        end
    end

    // Handshake flags come straight from the state register
    assign ready_o    = (r_state == ST_IDLE);
    assign valid_o    = (r_state == ST_DONE);
    assign bcd_o      = r_bcd;
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: directed boundary cases, abort by reset,
// and a random sweep against a decimal-arithmetic reference.
module tb_bin_to_bcd;

    logic        clk_i;
    logic        rst_ni;
    logic [15:0] binary_in;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] bcd_o;
    logic        valid_o;
    logic        overflow_o;

    int n_chk;
    int n_err;
    logic [16:0] prev_res;

    bin_to_bcd dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .binary_in  (binary_in),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .bcd_o      (bcd_o),
        .valid_o    (valid_o),
        .overflow_o (overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, packed BCD} from plain decimal arithmetic
    function automatic logic [16:0] ref_conv(input int unsigned v);
        logic [16:0] r;
        if (v > 9999) begin
            r = {1'b1, 16'h9999};
        end else begin
            r = {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
        end
        return r;
    endfunction

    // Starts and ends on a falling edge; noisy=1 scrambles binary_in and holds valid_i during SHIFT
    task automatic do_conv(input logic [15:0] v, input bit noisy);
        logic [16:0] exp;
        bit early;
        bit moved;
        bit busy_bad;
        int waits;
        exp = ref_conv(32'(v));
        waits = 0;
        while (ready_o !== 1'b1 && waits < 40) begin
            @(negedge clk_i);
            waits++;
        end
        chk("ready_before_req", 32'(ready_o), 32'd1);
        binary_in = v;
        valid_i   = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        if (!noisy) valid_i = 1'b0;
        early = 0; moved = 0; busy_bad = 0;
        for (int k = 1; k <= 16; k++) begin
            if (noisy) binary_in = 16'($urandom);
            if (ready_o !== 1'b0) busy_bad = 1;
            if (valid_o !== 1'b0) early = 1;
            if ({overflow_o, bcd_o} !== prev_res) moved = 1;
            @(posedge clk_i);
            @(negedge clk_i);
        end
        chk("busy_in_shift", 32'(busy_bad), 32'd0);
        chk("no_early_valid", 32'(early), 32'd0);
        chk("hold_in_shift", 32'(moved), 32'd0);
        chk("valid_at_latency", 32'(valid_o), 32'd1);
        chk("ready_in_done", 32'(ready_o), 32'd0);
        chk("bcd", 32'(bcd_o), 32'(exp[15:0]));
        chk("overflow", 32'(overflow_o), 32'(exp[16]));
        prev_res = exp;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        chk("single_pulse", 32'(valid_o), 32'd0);
        chk("ready_after_done", 32'(ready_o), 32'd1);
        chk("bcd_held", 32'(bcd_o), 32'(exp[15:0]));
    endtask

    initial begin
        bit stray;
        n_chk = 0;
        n_err = 0;
        prev_res = 17'd0;
        rst_ni = 1'b0;
        valid_i = 1'b0;
        binary_in = 16'd0;
        #2;
        chk("rst_bcd", 32'(bcd_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        do_conv(16'd256, 0);
        do_conv(16'd1234, 0);
        do_conv(16'd4995, 0);
        do_conv(16'd0, 0);
        do_conv(16'd9999, 0);
        do_conv(16'd10000, 0);
        do_conv(16'd65535, 0);
        do_conv(16'd1234, 1);

        // Abort a conversion of 4995 by reset after its eighth iteration
        binary_in = 16'd4995;
        valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (8) @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        chk("abort_bcd", 32'(bcd_o), 32'd0);
        chk("abort_ovf", 32'(overflow_o), 32'd0);
        chk("abort_valid", 32'(valid_o), 32'd0);
        chk("abort_ready", 32'(ready_o), 32'd1);
        prev_res = 17'd0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        stray = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (valid_o !== 1'b0) stray = 1;
        end
        chk("abort_no_pulse", 32'(stray), 32'd0);
        do_conv(16'd256, 0);

        for (int n = 0; n < 200; n++) begin
            do_conv(16'($urandom_range(0, 65535)), bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
